// File: rtl/data_mem_pkg.sv
// Shared widths and loader state encoding for the data-memory bulk loader.
package data_mem_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StVerify,
    StDone
  } loader_state_e;

endpackage

// File: rtl/data_mem_loader_if.sv
// Stream input and memory port of the loader, bundled as one interface.
interface data_mem_loader_if #(
  parameter int unsigned ADDR_W = data_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = data_mem_pkg::DATA_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  s_valid, s_data, mem_rdata,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output s_valid, s_data, mem_rdata,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/byte_sum_acc.sv
// Modulo-2^DATA_W additive accumulator with synchronous clear.
module byte_sum_acc #(
  parameter int unsigned DATA_W = data_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum_q <= '0;
    end else if (add) begin
      sum_q <= sum_q + din;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/data_mem_loader.sv
// Bulk loader: writes a byte stream into memory from base_addr, reads it back
// and compares checksums. Passes CPU memory signals through while idle.
module data_mem_loader #(
  parameter int unsigned ADDR_W = data_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = data_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              verify_ok,
  data_mem_loader_if.master bus
);

  import data_mem_pkg::*;

  localparam logic [ADDR_W:0]   RemOne = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  loader_state_e     state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   rem_q;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] checksum_q;
  logic              verify_ok_q;

  logic [DATA_W-1:0] load_sum;
  logic [DATA_W-1:0] vsum;
  logic [DATA_W-1:0] vsum_next;
  logic              load_fire;
  logic              last_rem;

  assign load_fire = (state_q == StLoad) && bus.s_valid;
  assign last_rem  = (rem_q == RemOne);
  assign vsum_next = vsum + bus.mem_rdata;

  byte_sum_acc #(.DATA_W(DATA_W)) u_load_sum (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q == StIdle) && start),
    .add   (load_fire),
    .din   (bus.s_data),
    .sum   (load_sum)
  );

  byte_sum_acc #(.DATA_W(DATA_W)) u_verify_sum (
    .clk   (clk),
    .reset (reset),
    .clr   (load_fire && last_rem),
    .add   (state_q == StVerify),
    .din   (bus.mem_rdata),
    .sum   (vsum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      base_q      <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      checksum_q  <= '0;
      verify_ok_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q     <= base_addr;
            len_q      <= length;
            ptr_q      <= base_addr;
            rem_q      <= length;
            checksum_q <= '0;
            // An empty load trivially verifies.
            if (length == '0) begin
              verify_ok_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              verify_ok_q <= 1'b0;
              state_q     <= StLoad;
            end
          end
        end
        StLoad: begin
          if (bus.s_valid) begin
            if (last_rem) begin
              ptr_q   <= base_q;
              rem_q   <= len_q;
              state_q <= StVerify;
            end else begin
              ptr_q <= ptr_q + PtrOne;
              rem_q <= rem_q - RemOne;
            end
          end
        end
        StVerify: begin
          ptr_q <= ptr_q + PtrOne;
          rem_q <= rem_q - RemOne;
          if (last_rem) begin
            checksum_q  <= load_sum;
            verify_ok_q <= (vsum_next == load_sum);
            state_q     <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = ptr_q;
    bus.mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        bus.mem_we    = cpu_we;
        bus.mem_addr  = cpu_addr;
        bus.mem_wdata = cpu_wdata;
      end
      StLoad: begin
        bus.mem_we    = bus.s_valid;
        bus.mem_wdata = bus.s_data;
      end
      default: begin
      end
    endcase
    if (reset) begin
      bus.mem_we = 1'b0;
    end
  end

  assign bus.s_ready = ~reset && (state_q == StLoad);
  assign busy        = ~reset && (state_q != StIdle);
  assign done        = ~reset && (state_q == StDone);
  assign checksum    = checksum_q;
  assign verify_ok   = verify_ok_q;

endmodule

// File: tb/tb_data_mem_loader.sv
// Directed bench for data_mem_loader: behavioural memory, expected-write
// scoreboard and literal checks on timing, checksum and memory contents.
module tb_data_mem_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic       verify_ok;

  data_mem_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  data_mem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .verify_ok (verify_ok),
    .bus       (bus)
  );

  // 256 x 8 memory: synchronous write, combinational read.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_sum;
  logic [7:0]  hold_sum = 8'h00;
  logic        hold_vok = 1'b0;
  bit          armed = 1'b0;
  logic [7:0]  bytes_buf [256];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every memory write during a load must be the next expected
  // (addr, byte); idle must be a pure passthrough; done only when expected.
  initial begin
    logic [7:0] ea;
    logic [7:0] ed;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(bus.s_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(bus.mem_we), 0);
      end else if (!busy) begin
        check("pt_we", int'(bus.mem_we), int'(cpu_we));
        check("pt_addr", int'(bus.mem_addr), int'(cpu_addr));
        check("pt_wdata", int'(bus.mem_wdata), int'(cpu_wdata));
        check("idle_ready", int'(bus.s_ready), 0);
        check("idle_checksum", int'(checksum), int'(hold_sum));
        check("idle_verify_ok", int'(verify_ok), int'(hold_vok));
      end else begin
        if (bus.mem_we) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            {ea, ed} = exp_q.pop_front();
            check("wr_addr", int'(bus.mem_addr), int'(ea));
            check("wr_data", int'(bus.mem_wdata), int'(ed));
            check("wr_ready", int'(bus.s_ready), 1);
          end
        end
        if (done) begin
          check("done_expected", int'(armed), 1);
          if (armed) begin
            check("done_checksum", int'(checksum), int'(exp_sum));
            check("done_verify_ok", int'(verify_ok), 1);
            check("done_all_written", exp_q.size(), 0);
            hold_sum = exp_sum;
            hold_vok = 1'b1;
            armed    = 1'b0;
          end
        end
      end
    end
  end

  // Cycle numbering: the cycle in which start is high is cycle 1.
  task automatic run_load(input logic [7:0] base, input int len, input int stall_at,
                          input int stall_n, input bit poke, input bit restart,
                          output int done_cyc);
    int         cyc;
    logic [7:0] a;
    bit         bad;
    exp_sum = 8'h00;
    for (int i = 0; i < len; i++) begin
      a = base + 8'(i);
      exp_q.push_back({a, bytes_buf[i]});
      exp_sum = exp_sum + bytes_buf[i];
    end
    armed = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = 9'(len); cyc = 1;
    @(posedge clk); #1;
    // Changing base/length after start must have no effect.
    start = 1'b0; base_addr = 8'h00; length = 9'd7; cyc = 2;
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_n; k++) begin
          bus.s_valid = 1'b0;
          if (poke && k == 0) begin
            cpu_we = 1'b1; cpu_addr = 8'h11; cpu_wdata = 8'hEE;
          end
          @(posedge clk); #1;
          cpu_we = 1'b0;
          cyc++;
        end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = bytes_buf[i];
      if (restart && i == 1) begin
        start = 1'b1; base_addr = 8'h80; length = 9'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    bus.s_valid = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (done) break;
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", int'(done), 1);
    done_cyc = cyc;
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
    check("idle_after_done", int'(busy), 0);
    bad = 1'b0;
    for (int i = 0; i < len; i++) begin
      a = base + 8'(i);
      if (mem[a] != bytes_buf[i]) bad = 1'b1;
    end
    check("mem_region", int'(bad), 0);
  endtask

  initial begin
    int dc;
    reset = 1'b1; start = 1'b0; base_addr = 8'h00; length = 9'd0;
    cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    bus.s_valid = 1'b0; bus.s_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_checksum", int'(checksum), 0);
    check("reset_verify_ok", int'(verify_ok), 0);

    // Passthrough in idle.
    cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h5A;
    #1;
    check("pt_lit_we", int'(bus.mem_we), 1);
    check("pt_lit_addr", int'(bus.mem_addr), 'h20);
    check("pt_lit_wdata", int'(bus.mem_wdata), 'h5A);
    check("pt_lit_busy", int'(busy), 0);
    @(posedge clk); #1;
    cpu_we = 1'b0;

    // Basic load.
    bytes_buf[0] = 8'h01; bytes_buf[1] = 8'h02; bytes_buf[2] = 8'h03; bytes_buf[3] = 8'hFF;
    run_load(8'h10, 4, -1, 0, 1'b0, 1'b0, dc);
    check("basic_done_cycle", dc, 10);
    check("basic_checksum", int'(checksum), 'h05);
    check("basic_verify_ok", int'(verify_ok), 1);
    check("basic_mem10", int'(mem[8'h10]), 'h01);
    check("basic_mem13", int'(mem[8'h13]), 'hFF);

    // Stalls plus dropped CPU write.
    run_load(8'h10, 4, 3, 3, 1'b1, 1'b0, dc);
    check("stall_done_cycle", dc, 13);
    check("stall_mem11", int'(mem[8'h11]), 'h02);
    check("stall_checksum", int'(checksum), 'h05);

    // Ignored start during LOAD.
    bytes_buf[0] = 8'hAA; bytes_buf[1] = 8'hBB; bytes_buf[2] = 8'hCC;
    run_load(8'h30, 3, -1, 0, 1'b0, 1'b1, dc);
    check("restart_done_cycle", dc, 8);
    check("restart_checksum", int'(checksum), 'h31);

    // Full length with address wrap.
    for (int i = 0; i < 256; i++) bytes_buf[i] = 8'(i);
    run_load(8'hFE, 256, -1, 0, 1'b0, 1'b0, dc);
    check("wrap_done_cycle", dc, 514);
    check("wrap_memFE", int'(mem[8'hFE]), 'h00);
    check("wrap_memFF", int'(mem[8'hFF]), 'h01);
    check("wrap_mem00", int'(mem[8'h00]), 'h02);
    check("wrap_checksum", int'(checksum), 'h80);
    check("wrap_verify_ok", int'(verify_ok), 1);

    // Zero length.
    run_load(8'h50, 0, -1, 0, 1'b0, 1'b0, dc);
    check("len0_done_cycle", dc, 2);
    check("len0_checksum", int'(checksum), 0);
    check("len0_verify_ok", int'(verify_ok), 1);

    // Reset during VERIFY.
    bytes_buf[0] = 8'h11; bytes_buf[1] = 8'h22; bytes_buf[2] = 8'h33; bytes_buf[3] = 8'h44;
    for (int i = 0; i < 4; i++) exp_q.push_back({8'h40 + 8'(i), bytes_buf[i]});
    exp_sum = 8'hAA;
    armed = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h40; length = 9'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1; bus.s_data = bytes_buf[i];
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    check("verify_busy", int'(busy), 1);
    reset = 1'b1;
    exp_q.delete();
    armed = 1'b0; hold_sum = 8'h00; hold_vok = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rv_busy", int'(busy), 0);
    check("rv_ready", int'(bus.s_ready), 0);
    cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 8'h77;
    #1;
    check("rv_pt_we", int'(bus.mem_we), 1);
    check("rv_pt_addr", int'(bus.mem_addr), 'h33);
    check("rv_pt_wdata", int'(bus.mem_wdata), 'h77);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rv_mem43", int'(mem[8'h43]), 'h44);
    check("rv_checksum", int'(checksum), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
